// File: rtl/cache_fill_controller.sv
// Memory-side responder for the I/D caches: D-miss, then write-through, then I-miss priority; `MISS_STATS_EN adds miss counters.
// Latency: a fill issues 8 reads from the cycle after the request and writes the tag with the last return; a write-through holds MEM_LATENCY cycles.
// Backpressure: ins_stall/mem_stall freeze the pipeline; DONE drops mem_stall for one cycle so a held data_wr can retire.
module cache_fill_controller #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ins_miss,
  input  logic [15:0] ins_miss_addr,
  input  logic        data_miss,
  input  logic [15:0] data_miss_addr,
  input  logic        data_wr,
  input  logic [15:0] data_wr_addr,
  input  logic [15:0] data_wr_data,
  output logic        ins_stall,
  output logic        mem_stall,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic [15:0] fill_addr,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        fill_ins_we,
  output logic        fill_data_we,
  output logic        fill_tag_we
`ifdef MISS_STATS_EN
  ,
  output logic [15:0] ins_miss_cnt,
  output logic [15:0] data_miss_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, FILL_I, FILL_D, WRITE, DONE} state_t;

  state_t      state;
  logic [3:0]  ic;
  logic [2:0]  rc;
  logic [7:0]  wc;
  logic [15:0] miss_addr;
  logic        start_d;
  logic        start_w;
  logic        start_i;

  assign start_d   = (state == IDLE) && data_miss;
  assign start_w   = (state == IDLE) && !data_miss && data_wr;
  assign start_i   = (state == IDLE) && !data_miss && !data_wr && ins_miss;
  assign miss_addr = data_miss ? data_miss_addr : ins_miss_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ic         <= '0;
      rc         <= '0;
      wc         <= '0;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fill_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
          if (start_d || start_i) begin
            state      <= start_d ? FILL_D : FILL_I;
            fill_addr  <= miss_addr & 16'hFFF0;
            mem_addr   <= miss_addr & 16'hFFF0;
            mem_enable <= 1'b1;
            ic         <= 4'd1;
            rc         <= 3'd0;
          end else if (start_w) begin
            state      <= WRITE;
            mem_addr   <= data_wr_addr;
            mem_wdata  <= data_wr_data;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b1;
            wc         <= 8'd0;
          end
        end
        FILL_I, FILL_D: begin
          // Base stays fixed; only the word field advances, so no carry leaves the block.
          if (ic[3]) begin
            mem_enable <= 1'b0;
          end else begin
            mem_enable <= 1'b1;
            mem_addr   <= {fill_addr[15:4], ic[2:0], 1'b0};
            ic         <= ic + 4'd1;
          end
          if (mem_data_valid) begin
            rc <= rc + 3'd1;
            if (rc == 3'd7) state <= DONE;
          end
        end
        WRITE: begin
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
          if (wc == 8'(MEM_LATENCY - 1)) state <= DONE;
          else wc <= wc + 8'd1;
        end
        DONE: begin
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fill_data    = mem_rdata;
  assign fill_word    = rc;
  assign fill_ins_we  = (state == FILL_I) && mem_data_valid;
  assign fill_data_we = (state == FILL_D) && mem_data_valid;
  assign fill_tag_we  = (fill_ins_we || fill_data_we) && (rc == 3'd7);

  // A pending I-miss keeps fetch stalled even while a D-fill or its DONE cycle runs first.
  assign ins_stall = ins_miss || (state == FILL_I);
  assign mem_stall = ((state == IDLE) && (data_miss || data_wr)) || (state == FILL_D) || (state == WRITE);

`ifdef MISS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_miss_cnt  <= '0;
      data_miss_cnt <= '0;
    end else begin
      if (start_i && ins_miss_cnt != 16'hFFFF) ins_miss_cnt <= ins_miss_cnt + 16'd1;
      if (start_d && data_miss_cnt != 16'hFFFF) data_miss_cnt <= data_miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed bench for cache_fill_controller with a 4-cycle read-latency memory model.
module tb_cache_fill_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_miss = 1'b0;
  logic [15:0] ins_miss_addr = '0;
  logic        data_miss = 1'b0;
  logic [15:0] data_miss_addr = '0;
  logic        data_wr = 1'b0;
  logic [15:0] data_wr_addr = '0;
  logic [15:0] data_wr_data = '0;
  logic        ins_stall, mem_stall, mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_addr, fill_data;
  logic        mem_data_valid, fill_ins_we, fill_data_we, fill_tag_we;
  logic [2:0]  fill_word;
`ifdef MISS_STATS_EN
  logic [15:0] ins_miss_cnt, data_miss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_fill_controller #(.MEM_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .ins_miss(ins_miss), .ins_miss_addr(ins_miss_addr),
    .data_miss(data_miss), .data_miss_addr(data_miss_addr),
    .data_wr(data_wr), .data_wr_addr(data_wr_addr), .data_wr_data(data_wr_data),
    .ins_stall(ins_stall), .mem_stall(mem_stall),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_addr(fill_addr), .fill_word(fill_word), .fill_data(fill_data),
    .fill_ins_we(fill_ins_we), .fill_data_we(fill_data_we), .fill_tag_we(fill_tag_we)
`ifdef MISS_STATS_EN
    , .ins_miss_cnt(ins_miss_cnt), .data_miss_cnt(data_miss_cnt)
`endif
  );

  // Memory: a read issued in cycle n returns ~addr in cycle n+4; shares rst.
  logic [3:0]  pv;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], mem_enable & ~mem_wr};
      pa[0] <= mem_addr;
      for (int i = 3; i > 0; i--) pa[i] <= pa[i-1];
    end
  end
  assign mem_data_valid = pv[3];
  assign mem_rdata      = pv[3] ? ~pa[3] : 16'h0000;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ins_stall, mem_stall, mem_enable, mem_wr, fill_ins_we, fill_data_we, fill_tag_we} !== 7'b0)
      begin errors++; $display("FAIL reset strobes got=%b exp=0", {ins_stall, mem_stall, mem_enable, mem_wr, fill_ins_we, fill_data_we, fill_tag_we}); end
    checks++;
    if ({mem_addr, mem_wdata, fill_addr, fill_data, fill_word} !== 67'b0)
      begin errors++; $display("FAIL reset buses got=%h exp=0", {mem_addr, mem_wdata, fill_addr, fill_data, fill_word}); end
  endtask

  task automatic test_fill_i(input logic [15:0] a, input string nm);
    logic [15:0] base;
    logic        e;
    base = a & 16'hFFF0;
    @(posedge clk); #1;
    ins_miss = 1'b1; ins_miss_addr = a;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 13) ins_miss = 1'b0;
      @(negedge clk);
      checks++; e = (c <= 12);
      if (ins_stall !== e) begin errors++; $display("FAIL %s ins_stall c=%0d got=%b exp=%b", nm, c, ins_stall, e); end
      checks++;
      if (mem_stall !== 1'b0 || fill_data_we !== 1'b0) begin errors++; $display("FAIL %s dside c=%0d got=%b%b exp=00", nm, c, mem_stall, fill_data_we); end
      checks++; e = (c >= 1 && c <= 8);
      if (mem_enable !== e) begin errors++; $display("FAIL %s mem_enable c=%0d got=%b exp=%b", nm, c, mem_enable, e); end
      if (e) begin
        checks++;
        if (mem_addr !== base + 16'(2*(c-1))) begin errors++; $display("FAIL %s mem_addr c=%0d got=%h exp=%h", nm, c, mem_addr, base + 16'(2*(c-1))); end
      end
      checks++; e = (c >= 5 && c <= 12);
      if (fill_ins_we !== e) begin errors++; $display("FAIL %s fill_ins_we c=%0d got=%b exp=%b", nm, c, fill_ins_we, e); end
      if (e) begin
        checks++;
        if (fill_word !== 3'(c-5) || fill_data !== ~(base + 16'(2*(c-5))))
          begin errors++; $display("FAIL %s fill c=%0d got=%0d/%h exp=%0d/%h", nm, c, fill_word, fill_data, c-5, ~(base + 16'(2*(c-5)))); end
      end
      checks++; e = (c == 12);
      if (fill_tag_we !== e) begin errors++; $display("FAIL %s fill_tag_we c=%0d got=%b exp=%b", nm, c, fill_tag_we, e); end
      if (c == 12) begin
        checks++;
        if (fill_addr !== base) begin errors++; $display("FAIL %s fill_addr got=%h exp=%h", nm, fill_addr, base); end
      end
    end
  endtask

  task automatic test_dual_miss();
    logic e;
    @(posedge clk); #1;
    ins_miss = 1'b1; ins_miss_addr = 16'h2002;
    data_miss = 1'b1; data_miss_addr = 16'h4008;
    for (int c = 0; c <= 28; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 13) data_miss = 1'b0;
      if (c == 27) ins_miss = 1'b0;
      @(negedge clk);
      checks++; e = (c <= 26);
      if (ins_stall !== e) begin errors++; $display("FAIL dual ins_stall c=%0d got=%b exp=%b", c, ins_stall, e); end
      checks++; e = (c <= 12);
      if (mem_stall !== e) begin errors++; $display("FAIL dual mem_stall c=%0d got=%b exp=%b", c, mem_stall, e); end
      checks++; e = (c >= 1 && c <= 8) || (c >= 15 && c <= 22);
      if (mem_enable !== e) begin errors++; $display("FAIL dual mem_enable c=%0d got=%b exp=%b", c, mem_enable, e); end
      if (c == 1 || c == 15) begin
        checks++;
        if (mem_addr !== ((c == 1) ? 16'h4000 : 16'h2000)) begin errors++; $display("FAIL dual mem_addr c=%0d got=%h", c, mem_addr); end
      end
      checks++; e = (c >= 5 && c <= 12);
      if (fill_data_we !== e) begin errors++; $display("FAIL dual fill_data_we c=%0d got=%b exp=%b", c, fill_data_we, e); end
      checks++; e = (c >= 19 && c <= 26);
      if (fill_ins_we !== e) begin errors++; $display("FAIL dual fill_ins_we c=%0d got=%b exp=%b", c, fill_ins_we, e); end
      checks++; e = (c == 12 || c == 26);
      if (fill_tag_we !== e) begin errors++; $display("FAIL dual fill_tag_we c=%0d got=%b exp=%b", c, fill_tag_we, e); end
      if (c == 12 || c == 26) begin
        checks++;
        if (fill_addr !== ((c == 12) ? 16'h4000 : 16'h2000) || fill_word !== 3'd7)
          begin errors++; $display("FAIL dual tag c=%0d got=%h/%0d", c, fill_addr, fill_word); end
      end
    end
  endtask

  task automatic test_write();
    logic e;
    @(posedge clk); #1;
    data_wr = 1'b1; data_wr_addr = 16'h0100; data_wr_data = 16'hBEEF;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 6) data_wr = 1'b0;
      @(negedge clk);
      checks++; e = (c == 1);
      if (mem_enable !== e || mem_wr !== e) begin errors++; $display("FAIL write strobe c=%0d got=%b%b exp=%b%b", c, mem_enable, mem_wr, e, e); end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 16'h0100 || mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL write bus got=%h/%h exp=0100/beef", mem_addr, mem_wdata); end
      end
      checks++; e = (c <= 4);
      if (mem_stall !== e) begin errors++; $display("FAIL write mem_stall c=%0d got=%b exp=%b", c, mem_stall, e); end
      checks++;
      if (ins_stall !== 1'b0 || mem_data_valid !== 1'b0) begin errors++; $display("FAIL write side c=%0d got=%b%b exp=00", c, ins_stall, mem_data_valid); end
    end
  endtask

  task automatic test_write_before_imiss();
    logic e;
    @(posedge clk); #1;
    data_wr = 1'b1; data_wr_addr = 16'h0200; data_wr_data = 16'h1234;
    ins_miss = 1'b1; ins_miss_addr = 16'h5004;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 6) data_wr = 1'b0;
      if (c == 19) ins_miss = 1'b0;
      @(negedge clk);
      checks++; e = (c <= 18);
      if (ins_stall !== e) begin errors++; $display("FAIL prio ins_stall c=%0d got=%b exp=%b", c, ins_stall, e); end
      if (c == 1 || c == 7) begin
        checks++;
        if (mem_enable !== 1'b1 || mem_wr !== (c == 1) || mem_addr !== ((c == 1) ? 16'h0200 : 16'h5000))
          begin errors++; $display("FAIL prio issue c=%0d got=%b%b/%h", c, mem_enable, mem_wr, mem_addr); end
      end
      checks++; e = (c == 18);
      if (fill_tag_we !== e) begin errors++; $display("FAIL prio fill_tag_we c=%0d got=%b exp=%b", c, fill_tag_we, e); end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic e;
    @(posedge clk); #1;
    ins_miss = 1'b1; ins_miss_addr = 16'h3000;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 7) begin rst = 1'b1; ins_miss = 1'b0; end
      if (c == 8) rst = 1'b0;
      @(negedge clk);
      if (c <= 7) begin
        checks++; e = (c >= 5);
        if (fill_ins_we !== e) begin errors++; $display("FAIL rstfill we c=%0d got=%b exp=%b", c, fill_ins_we, e); end
      end else begin
        checks++;
        if ({ins_stall, mem_stall, mem_enable, mem_wr, fill_ins_we, fill_data_we, fill_tag_we} !== 7'b0)
          begin errors++; $display("FAIL rstfill strobes c=%0d got=%b exp=0", c, {ins_stall, mem_stall, mem_enable, mem_wr, fill_ins_we, fill_data_we, fill_tag_we}); end
        if (c == 8) begin
          checks++;
          if ({mem_addr, mem_wdata, fill_addr, fill_data, fill_word} !== 67'b0)
            begin errors++; $display("FAIL rstfill buses got=%h exp=0", {mem_addr, mem_wdata, fill_addr, fill_data, fill_word}); end
        end
      end
    end
  endtask

`ifdef MISS_STATS_EN
  task automatic test_stats();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ins_miss_cnt !== 16'd0 || data_miss_cnt !== 16'd0) begin errors++; $display("FAIL stats clear got=%h/%h exp=0/0", ins_miss_cnt, data_miss_cnt); end
    test_fill_i(16'h0010, "stats1");
    test_fill_i(16'h0020, "stats2");
    checks++;
    if (ins_miss_cnt !== 16'd2 || data_miss_cnt !== 16'd0) begin errors++; $display("FAIL stats count got=%h/%h exp=2/0", ins_miss_cnt, data_miss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_i(16'h1236, "ifill");
    test_dual_miss();
    test_write();
    test_write_before_imiss();
    test_fill_i(16'hFFFE, "wrap");
    test_reset_mid_fill();
    test_fill_i(16'h3000, "restart");
`ifdef MISS_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
